// File: rtl/rstring_tap_seq_if.sv
// rstring_tap_seq_if: tap-select request/status and analog supply/output bundle for rstring_tap_seq.
interface rstring_tap_seq_if #(
  parameter int N_TAPS = 8
) ();
  localparam int SEL_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  real avdd;
  logic ena;
  logic req;
  logic [SEL_W-1:0] code;
  logic [N_TAPS-1:0] tap_sel;
  real vin;
  logic busy;
  logic ack;
  logic err;
  modport master (output avdd, ena, req, code, input tap_sel, vin, busy, ack, err);
  modport slave (input avdd, ena, req, code, output tap_sel, vin, busy, ack, err);
endinterface

// File: rtl/rstring_tap_seq.sv
// rstring_tap_seq: break-before-make resistor-string tap sequencer with analog mux output model.
// Define RSTRING_RAMP_EN to step one tap at a time toward the target instead of jumping directly.
module rstring_tap_seq #(
  parameter int N_TAPS      = 8,
  parameter int BASE_UNITS  = 28,
  parameter int TOTAL_UNITS = 70,
  parameter int BBM_CYC     = 2,
  parameter int SETTLE_CYC  = 8,
  parameter int RST_TAP     = 0
) (
  input logic clk,
  input logic rst,
  rstring_tap_seq_if.slave bus
);
  localparam int SEL_W   = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam int CNT_MAX = (BBM_CYC > SETTLE_CYC) ? BBM_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  typedef enum logic [1:0] {IDLE, BREAK, SETTLE, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] cur_q, cur_d, tgt_q, tgt_d, step;
  logic err_q, err_d;
`ifdef RSTRING_RAMP_EN
  assign step = (tgt_q > cur_q) ? cur_q + SEL_W'(1) : cur_q - SEL_W'(1);
`else
  assign step = tgt_q;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.req) begin
          if (int'(bus.code) >= N_TAPS) err_d = 1'b1;
          else begin
            tgt_d   = bus.code;
            state_d = (bus.code == cur_q) ? DONE : BREAK;
          end
        end
      end
      BREAK:
        if (cnt_q == CNT_W'(BBM_CYC - 1)) begin
          state_d = SETTLE;
          cnt_d   = '0;
          cur_d   = step;
        end
      SETTLE:
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          state_d = (cur_q == tgt_q) ? DONE : BREAK;
          cnt_d   = '0;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= SEL_W'(RST_TAP);
      tgt_q   <= SEL_W'(RST_TAP);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      err_q   <= err_d;
    end
  end
  assign bus.tap_sel = (state_q == BREAK) ? '0 : N_TAPS'(1) << cur_q;
  assign bus.busy    = (state_q == BREAK) || (state_q == SETTLE);
  assign bus.ack     = (state_q == DONE);
  assign bus.err     = err_q;
  // Open string (all taps off) reads as ground; disabled string passes the top supply.
  always_comb begin
    bus.vin = !bus.ena ? bus.avdd :
              (state_q == BREAK) ? 0.0 :
              bus.avdd * real'(BASE_UNITS + N_TAPS - 1 - int'(cur_q)) / real'(TOTAL_UNITS);
  end
endmodule
